// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the session FSM state encoding, error codes and header width.
// Imported by imem_loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } loader_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;   // header word count exceeds memory depth
    localparam logic [1:0] ERR_TMO  = 2'b10;   // byte stream stalled too long

    localparam int HDR_CNT_W = 16;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a 2-byte LE word count, packs LE bytes into 32-bit words, writes imem.
// Latency: we_o asserts the cycle after the 4th byte handshake of a word (one WRITE cycle).
// Backpressure: byte_ready_o is high only in HDR_LO/HDR_HI/DATA; it drops for the WRITE cycle.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i                       pulse; starts a session from IDLE/DONE/ERR, ignored while busy
//   byte_valid_i/byte_data_i/byte_ready_o   incoming byte stream handshake
//   we_o/waddr_o/wdata_o          instruction memory write port (waddr_o is a byte address)
//   cpu_rst_no                    core reset, low while loading or after an error
//   busy_o/done_o/err_o/err_code_o  session status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_W      = 13,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [IMEM_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              cpu_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned DEPTH = 32'd1 << (IMEM_W - 2);

    loader_state_e          r_state;
    loader_state_e          w_state_nxt;

    logic [HDR_CNT_W-1:0]   r_word_cnt;
    logic [HDR_CNT_W-1:0]   r_word_idx;
    logic [1:0]             r_byte_cnt;
    logic [31:0]            r_asm;
    logic [31:0]            r_tmo;
    logic [1:0]             r_err_code;

    logic                   w_rdy;
    logic                   w_hs;
    logic                   w_tmo_hit;
    logic                   w_new_sess;
    logic [HDR_CNT_W-1:0]   w_hdr_cnt;
    logic                   w_hdr_ovf;
    logic                   w_last;
    logic                   w_err_set;
    logic [1:0]             w_err_val;

    assign w_rdy      = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) || (r_state == S_DATA);
    assign w_hs       = w_rdy && byte_valid_i;
    // Stall counter trips on the cycle whose increment would reach the limit,
    // so ERR is entered exactly TIMEOUT_CYC cycles after the last accepted byte.
    assign w_tmo_hit  = (TIMEOUT_CYC != 32'd0) && w_rdy && !w_hs
                        && ((r_tmo + 32'd1) == TIMEOUT_CYC);
    assign w_new_sess = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // Full count as it will be once the high header byte is taken this cycle.
    assign w_hdr_cnt  = {byte_data_i, r_word_cnt[7:0]};
    assign w_hdr_ovf  = 32'(w_hdr_cnt) > DEPTH;
    assign w_last     = (r_word_idx + 16'd1) == r_word_cnt;

    // Next-state and outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_err_set    = 1'b0;
        w_err_val    = ERR_NONE;
        we_o         = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        cpu_rst_no   = 1'b0;

        case (r_state)
            S_IDLE: begin
                cpu_rst_no = 1'b1;
                if (start_i) w_state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                busy_o = 1'b1;
                if (w_hs) begin
                    w_state_nxt = S_HDR_HI;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TMO;
                end
            end
            S_HDR_HI: begin
                busy_o = 1'b1;
                if (w_hs) begin
                    if (w_hdr_cnt == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (w_hdr_ovf) begin
                        w_state_nxt = S_ERR;
                        w_err_set   = 1'b1;
                        w_err_val   = ERR_OVF;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TMO;
                end
            end
            S_DATA: begin
                busy_o = 1'b1;
                if (w_hs) begin
                    if (r_byte_cnt == 2'd3) w_state_nxt = S_WRITE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TMO;
                end
            end
            S_WRITE: begin
                busy_o      = 1'b1;
                we_o        = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done_o     = 1'b1;
                cpu_rst_no = 1'b1;
                if (start_i) w_state_nxt = S_HDR_LO;
            end
            S_ERR: begin
                err_o = 1'b1;
                if (start_i) w_state_nxt = S_HDR_LO;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign byte_ready_o = w_rdy;
    assign waddr_o      = IMEM_W'({r_word_idx, 2'b00});
    assign wdata_o      = r_asm;
    assign err_code_o   = r_err_code;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: header count, word index, byte assembly, stall counter, error code
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_word_cnt <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_tmo      <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_new_sess) begin
                r_word_cnt <= '0;
                r_word_idx <= '0;
                r_byte_cnt <= '0;
                r_tmo      <= '0;
                r_err_code <= ERR_NONE;
            end

            if (w_hs) begin
                r_tmo <= '0;
                case (r_state)
                    S_HDR_LO: r_word_cnt[7:0]  <= byte_data_i;
                    S_HDR_HI: r_word_cnt[15:8] <= byte_data_i;
                    S_DATA: begin
                        // Shift in from the top: after 4 bytes the first lands in [7:0].
                        r_asm      <= {byte_data_i, r_asm[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end else if (w_rdy) begin
                r_tmo <= r_tmo + 32'd1;
            end

            if (r_state == S_WRITE) begin
                r_word_idx <= r_word_idx + 16'd1;
            end

            if (w_err_set) begin
                r_err_code <= w_err_val;
            end
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time programmer for the instruction memory. It receives a byte stream (UART RX or debug bridge) over a valid/ready handshake, parses a 2-byte word-count header, and assembles little-endian 32-bit words. It drives the instruction memory write port and holds the core in reset while loading. It sits between the serial front-end and the instruction memory's write-side port; the core's fetch read port is untouched.

Parameters:
IMEM_W, 13, instruction memory byte-address width; depth = 2**(IMEM_W-2) words
TIMEOUT_CYC, 1000000, max idle cycles between accepted bytes while loading; 0 disables the timeout

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  single-cycle pulse that begins a load session
byte_valid_i  in  1  byte_data_i holds a valid byte
byte_data_i  in  8  incoming byte
byte_ready_o  out  1  loader accepts a byte this cycle
we_o  out  1  instruction memory write enable
waddr_o  out  IMEM_W  byte address of the write; [1:0] always 0
wdata_o  out  32  assembled instruction word
cpu_rst_no  out  1  active-low reset to the core; 0 while loading or in error
busy_o  out  1  session in progress
done_o  out  1  level; last session completed cleanly
err_o  out  1  level; last session failed
err_code_o  out  2  01 = overflow (count > depth), 10 = timeout, 00 = none

Behaviour:
- Clock is clk_i. Reset is synchronous, active-low on rst_ni, sampled on the rising edge of clk_i.
- Handshake: a byte is accepted only when byte_valid_i && byte_ready_o. A byte is never consumed without that.
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
- IDLE: on start_i go to HDR_LO. Clear the word counter, byte counter, timeout counter, done_o, err_o and err_code_o.
- HDR_LO / HDR_HI: accept the count low byte, then the high byte, into a 16-bit word_cnt.
- On leaving HDR_HI:
  - word_cnt == 0 -> DONE.
  - word_cnt > 2**(IMEM_W-2) -> ERR with code 01.
  - Otherwise -> DATA.
- DATA: accept bytes LSB-first into a 32-bit shift/assembly register. After the 4th byte of a word, go to WRITE.
- WRITE: exactly one cycle.
  - we_o=1, waddr_o = word_idx<<2, wdata_o = assembled word. byte_ready_o=0.
  - Then increment word_idx. If word_idx+1 == word_cnt -> DONE, else -> DATA.
- Write latency: we_o is asserted the cycle after the 4th byte handshake.
- DONE: done_o=1, cpu_rst_no=1. start_i -> HDR_LO (new session).
- ERR: err_o=1, err_code_o held, cpu_rst_no=0. Sticky until start_i (-> HDR_LO) or reset.
- Timeout:
  - Applies in HDR_LO, HDR_HI and DATA.
  - The counter increments each cycle without a handshake and clears on every accepted byte.
  - Reaching TIMEOUT_CYC -> ERR with code 10.
  - Disabled when TIMEOUT_CYC == 0.
- start_i while busy (HDR_LO..WRITE) is ignored.
- byte_ready_o=1 only in HDR_LO, HDR_HI and DATA.
- busy_o=1 in HDR_LO, HDR_HI, DATA and WRITE.
- cpu_rst_no=1 in IDLE and DONE, 0 otherwise.
- Outputs during reset / after reset: state IDLE; we_o=0, waddr_o=0, wdata_o=0, byte_ready_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=00, cpu_rst_no=1.
- we_o is never 1 outside WRITE. waddr_o and wdata_o may hold stale values when we_o=0.
- Words are written in strictly ascending order from address 0. No wrap-around is possible, because overflow is rejected at the header.
- Reset mid-session: returns to IDLE immediately; memory contents already written are left as-is.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum loader_state_e.
  - err code localparams ERR_NONE / ERR_OVF / ERR_TMO.
  - Header width constant HDR_CNT_W=16.
- A single module is sufficient; no sub-module.
- The instruction memory gains a synchronous write port (we/waddr/wdata) as a separate change.

Test Plan:
- Header 02 00, then bytes 13 05 10 00 93 05 20 00 with valid held high -> we_o pulses twice: addr 0x000 data 0x00100513, then addr 0x004 data 0x00200593. Then done_o=1 and cpu_rst_no rises.
- Header 00 00 -> DONE two handshakes after start, no we_o pulse, err_o=0.
- Header 01 08 (0x0801 > 2048 words at IMEM_W=13) -> ERR, err_code_o=01, cpu_rst_no=0, no writes.
- TIMEOUT_CYC=16: header 01 00, one data byte, then valid low -> ERR with code 10 exactly 16 cycles after the last handshake.
- Random valid gaps plus start_i pulsed mid-DATA -> the pulse is ignored, data still matches; byte_ready_o=0 in every WRITE cycle.
- rst_ni low mid-DATA for 1 cycle -> IDLE, all outputs at reset values. A subsequent start_i with a valid stream loads correctly.
